ysyx_24120013_reg_file: RTL
===========================

YSYX_24120013_REG_FILE -- requirements
Module: ysyx_24120013_reg_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each general-purpose register.
REQ-002 Parameter REG_NUM, default 32, register count; index width fixed at 5 bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 EXU_wen  input  1  write request from EXU.
REQ-006 EXU_waddr  input  5  destination register index.
REQ-007 EXU_wdata  input  DATA_WIDTH  write data.
REQ-008 iss_valid  input  1  issue of an instruction with a destination register; marks it pending.
REQ-009 iss_rd  input  5  destination index of issued instruction.
REQ-010 raddr1, raddr2  input  5 each  read port indices.
REQ-011 rdata1, rdata2  output  DATA_WIDTH each  read port data.
REQ-012 rbusy1, rbusy2  output  1 each  read register has a pending write.
REQ-013 iss_ready  output  1  issue may be accepted (iss_rd not already pending).

Function
REQ-014 Register storage SHALL be REG_NUM x DATA_WIDTH flops; x0 SHALL read 0 always and never be stored or marked pending.
REQ-015 Write: when EXU_wen=1 and EXU_waddr!=0, regs[EXU_waddr] SHALL take EXU_wdata at the next rising clk.
REQ-016 Reads SHALL be combinational: rdataN = regs[raddrN], with raddrN=0 giving 0.
REQ-017 Write bypass: when EXU_wen=1, EXU_waddr!=0 and EXU_waddr==raddrN in the same cycle, rdataN SHALL equal EXU_wdata.
REQ-018 Scoreboard: one busy bit per register, busy[0] hard 0.
REQ-019 Issue accepted when iss_valid=1 and iss_ready=1; accepted issue with iss_rd!=0 SHALL set busy[iss_rd] next cycle.
REQ-020 iss_ready SHALL be 0 when iss_rd!=0 and busy[iss_rd]=1 and no same-cycle write to iss_rd; else 1 (WAW stall).
REQ-021 A write with EXU_waddr!=0 SHALL clear busy[EXU_waddr] next cycle.
REQ-022 Simultaneous accepted issue and write to the same index: busy SHALL end set (issue wins), data SHALL be written.
REQ-023 rbusyN SHALL be busy[raddrN], forced 0 when a same-cycle write targets raddrN (bypass covers it), and 0 for raddrN=0.
REQ-024 Write to a register not marked busy SHALL still update data; busy stays 0.
REQ-025 Writes or issues to index 0 SHALL have no effect on any state.
REQ-026 Read-to-data latency 0 cycles; write-to-storage latency 1 cycle; issue-to-busy latency 1 cycle.

Reset
REQ-027 rst=0 SHALL immediately (no clock) clear all registers and all busy bits; rdataN=0, rbusyN=0, iss_ready=1.
REQ-028 While rst=0, writes and issues SHALL be ignored.
REQ-029 Reset asserted mid-operation SHALL discard pending writes and busy marks; first edge after release SHALL behave as from reset.
REQ-030 After reset release, first write SHALL take effect on the first rising clk with rst=1.

Verification
REQ-031 Reset: load x5=0x1234, pulse rst low between clock edges -> rdata1(raddr1=5)=0 immediately, rbusy1=0.
REQ-032 Write/read: EXU_wen=1, waddr=3, wdata=0xDEADBEEF, raddr1=3 same cycle -> rdata1=0xDEADBEEF (bypass); next cycle wen=0 -> still 0xDEADBEEF.
REQ-033 x0: wen=1, waddr=0, wdata=0xFFFFFFFF; iss_valid=1, iss_rd=0 -> rdata(raddr=0)=0, rbusy=0, iss_ready=1 on every cycle.
REQ-034 Scoreboard: issue rd=7 -> next cycle rbusy1(raddr1=7)=1, iss_ready=0 for iss_rd=7; write x7=0x42 -> same cycle rbusy1=0, rdata1=0x42; next cycle busy clear.
REQ-035 Collision: x9 busy, same cycle write x9=0x55 and issue rd=9 -> iss_ready=1, next cycle regs[9]=0x55 and rbusy=1.
REQ-036 Dual read: x1=0x11, x2=0x22, raddr1=2, raddr2=1 -> rdata1=0x22, rdata2=0x11; write x2=0x33 same cycle -> rdata1=0x33, rdata2=0x11.

Source files
------------

// File: rtl/ysyx_24120013_reg_file.sv
// General-purpose register file with write bypass and a per-register pending-write
// scoreboard that stalls issue on WAW hazards. x0 is hard-wired to zero.
module ysyx_24120013_reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EXU_wen,
    input  logic [4:0]            EXU_waddr,
    input  logic [DATA_WIDTH-1:0] EXU_wdata,
    input  logic                  iss_valid,
    input  logic [4:0]            iss_rd,
    input  logic [4:0]            raddr1,
    input  logic [4:0]            raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  rbusy1,
    output logic                  rbusy2,
    output logic                  iss_ready
);

    logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
    logic [DATA_WIDTH-1:0] regs_d [REG_NUM];
    logic [REG_NUM-1:0]    busy_q;
    logic [REG_NUM-1:0]    busy_d;

    logic wr_hit;
    logic iss_acc;
    logic byp1;
    logic byp2;

    // Indices at or beyond REG_NUM select nothing and read as zero / not busy.
    function automatic logic [DATA_WIDTH-1:0] reg_sel(
        input logic [DATA_WIDTH-1:0] r [REG_NUM],
        input logic [4:0]            a
    );
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            if (a == 5'(i)) v = r[i];
        end
        return v;
    endfunction

    function automatic logic busy_sel(
        input logic [REG_NUM-1:0] b,
        input logic [4:0]         a
    );
        logic v;
        v = 1'b0;
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            if (a == 5'(i)) v = b[i];
        end
        return v;
    endfunction

    function automatic logic idx_valid(input logic [4:0] a);
        return (a != 5'd0) && (32'(a) < REG_NUM);
    endfunction

    always_comb begin
        // Gating with rst keeps the bypass and stall logic quiet during reset.
        wr_hit    = rst && EXU_wen && idx_valid(EXU_waddr);
        iss_ready = 1'b1;
        if (idx_valid(iss_rd) && busy_sel(busy_q, iss_rd) &&
            !(wr_hit && (EXU_waddr == iss_rd))) begin
            iss_ready = 1'b0;
        end
        iss_acc = rst && iss_valid && iss_ready && idx_valid(iss_rd);
    end

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned i = 1; i < REG_NUM; i++) begin
            if (wr_hit && (EXU_waddr == 5'(i))) begin
                regs_d[i] = EXU_wdata;
                busy_d[i] = 1'b0;
            end
            // Applied after the clear so a same-cycle issue leaves the register pending.
            if (iss_acc && (iss_rd == 5'(i))) busy_d[i] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        byp1   = wr_hit && (EXU_waddr == raddr1);
        byp2   = wr_hit && (EXU_waddr == raddr2);
        rdata1 = byp1 ? EXU_wdata : reg_sel(regs_q, raddr1);
        rdata2 = byp2 ? EXU_wdata : reg_sel(regs_q, raddr2);
        rbusy1 = byp1 ? 1'b0 : busy_sel(busy_q, raddr1);
        rbusy2 = byp2 ? 1'b0 : busy_sel(busy_q, raddr2);
    end

endmodule
